cdc_handshake_tx: RTL and testbench

Source-side (transmitter) end of a 4-phase req/ack clock-domain-crossing handshake; it is the counterpart of our destination-side synchronizer chains. It accepts a data word via valid/ready, holds it stable on tx_data, and raises tx_req. It then waits for the destination's asynchronous tx_ack, which it synchronizes internally, before accepting the next word. It lives entirely in the source clock domain and serves as a launch point for inter-clock uncertainty and false-path constraints.

---
 rtl/cdc_handshake_tx.sv | 144 ++++++++++++++
 tb/tb_cdc_handshake_tx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/cdc_handshake_tx.sv
// Source-side end of a 4-phase req/ack clock-domain crossing: launches a held word with tx_req
// and waits for the synchronized tx_ack. Optional REQ timeout is enabled with CDC_TX_TIMEOUT_EN.
module cdc_handshake_tx #(
   parameter int DATA_WIDTH     = 8,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_req,
   input  logic                  tx_ack,
   output logic                  busy,
   output logic [15:0]           xfer_count,
   output logic                  timeout_err
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_REQ     = 2'd1;
   localparam logic [1:0] ST_ACK_LOW = 2'd2;

   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("cdc_handshake_tx: SYNC_STAGES must be 2..4");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("cdc_handshake_tx: TIMEOUT_CYCLES must be 1..65535");
   end

   logic [1:0]            state_q, state_d;
   logic                  tx_req_q, tx_req_d;
   logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
   logic [15:0]           xfer_q, xfer_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                  ack_sync;
   logic                  skip_inc;

   // tx_ack is sampled only by the first flop of this chain
   always_ff @(posedge clk) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], tx_ack};
   end
   assign ack_sync = sync_q[SYNC_STAGES-1];

`ifdef CDC_TX_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] to_cnt_q, to_cnt_d;
   logic        to_err_q, to_err_d;
   logic        to_hit_q, to_hit_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt_q <= '0;
         to_err_q <= 1'b0;
         to_hit_q <= 1'b0;
      end else begin
         to_cnt_q <= to_cnt_d;
         to_err_q <= to_err_d;
         to_hit_q <= to_hit_d;
      end
   end
   assign timeout_err = to_err_q;
   assign skip_inc    = to_hit_q;
`else
   assign timeout_err = 1'b0;
   assign skip_inc    = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      tx_req_d  = tx_req_q;
      tx_data_d = tx_data_q;
      xfer_d    = xfer_q;
`ifdef CDC_TX_TIMEOUT_EN
      to_cnt_d  = to_cnt_q;
      to_err_d  = to_err_q;
      to_hit_d  = to_hit_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready) begin
               tx_data_d = in_data;
               tx_req_d  = 1'b1;
               state_d   = ST_REQ;
`ifdef CDC_TX_TIMEOUT_EN
               to_cnt_d  = '0;
               to_hit_d  = 1'b0;
`endif
            end
         end
         ST_REQ: begin
`ifdef CDC_TX_TIMEOUT_EN
            to_cnt_d = to_cnt_q + 16'd1;
`endif
            if (ack_sync) begin
               tx_req_d = 1'b0;
               state_d  = ST_ACK_LOW;
            end
`ifdef CDC_TX_TIMEOUT_EN
            else if (to_cnt_q == TO_LAST) begin
               // abandon this word; ACK_LOW still waits for a quiet ack before re-arming
               tx_req_d = 1'b0;
               to_err_d = 1'b1;
               to_hit_d = 1'b1;
               state_d  = ST_ACK_LOW;
            end
`endif
         end
         ST_ACK_LOW: begin
            if (!ack_sync) begin
               state_d = ST_IDLE;
               if (!skip_inc) xfer_d = xfer_q + 16'd1;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            tx_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         tx_req_q  <= 1'b0;
         tx_data_q <= '0;
         xfer_q    <= '0;
      end else begin
         state_q   <= state_d;
         tx_req_q  <= tx_req_d;
         tx_data_q <= tx_data_d;
         xfer_q    <= xfer_d;
      end
   end

   assign in_ready   = (state_q == ST_IDLE) && !ack_sync;
   assign busy       = (state_q != ST_IDLE);
   assign tx_req     = tx_req_q;
   assign tx_data    = tx_data_q;
   assign xfer_count = xfer_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx: reset, single and streamed handshakes, stale ack,
// mid-handshake reset, and the REQ timeout when CDC_TX_TIMEOUT_EN is defined.
module tb_cdc_handshake_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] tx_data;
   logic       tx_req;
   logic       tx_ack;
   logic       busy;
   logic [15:0] xfer_count;
   logic       timeout_err;

   int n_checks = 0;
   int n_fail   = 0;

   cdc_handshake_tx #(
      .DATA_WIDTH    (8),
      .SYNC_STAGES   (2),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .tx_data    (tx_data),
      .tx_req     (tx_req),
      .tx_ack     (tx_ack),
      .busy       (busy),
      .xfer_count (xfer_count),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic wait_req(input logic v);
      for (int i = 0; i < 50 && tx_req !== v; i++) @(negedge clk);
      check("wait_req", 32'(tx_req), 32'(v));
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 50 && busy !== 1'b0; i++) @(negedge clk);
      check("wait_idle", 32'(busy), 32'd0);
   endtask

   // one word with a responder raising ack 3 cycles after req and dropping it 3 cycles after req falls
   task automatic xfer_word(input logic [7:0] d);
      @(negedge clk);
      in_data  = d;
      in_valid = 1'b1;
      check("x_rdy_pre", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      check("x_req_up", 32'(tx_req), 32'd1);
      check("x_data", 32'(tx_data), 32'(d));
      check("x_rdy_busy", 32'(in_ready), 32'd0);
      check("x_busy", 32'(busy), 32'd1);
      repeat (2) @(negedge clk);
      tx_ack = 1'b1;
      @(negedge clk);
      check("x_req_e1", 32'(tx_req), 32'd1);
      @(negedge clk);
      check("x_req_e2", 32'(tx_req), 32'd1);
      @(negedge clk);
      check("x_req_e3", 32'(tx_req), 32'd0);
      check("x_data_acklow", 32'(tx_data), 32'(d));
      repeat (2) @(negedge clk);
      tx_ack = 1'b0;
      repeat (2) @(negedge clk);
      check("x_busy_acklow", 32'(busy), 32'd1);
      @(negedge clk);
      check("x_busy_done", 32'(busy), 32'd0);
      check("x_rdy_done", 32'(in_ready), 32'd1);
      check("x_data_done", 32'(tx_data), 32'(d));
   endtask

   initial begin
      logic saw_req;
      logic saw_rdy;
      int   n;

      rst = 1'b1; tx_ack = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req", 32'(tx_req), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rdy", 32'(in_ready), 32'd1);
      check("rst_cnt", 32'(xfer_count), 32'd0);
      check("rst_data", 32'(tx_data), 32'd0);
      check("rst_terr", 32'(timeout_err), 32'd0);
      rst = 1'b0;

      xfer_word(8'hA5);
      check("single_cnt", 32'(xfer_count), 32'd1);

      // stream with in_valid held; in_data is changed while busy and must be ignored
      @(negedge clk);
      in_data  = 8'h01;
      in_valid = 1'b1;
      for (int w = 1; w <= 4; w++) begin
         wait_req(1'b1);
         check("st_data", 32'(tx_data), 32'(w));
         check("st_rdy_low", 32'(in_ready), 32'd0);
         if (w < 4) in_data = 8'(w + 1);
         else       in_valid = 1'b0;
         tx_ack = 1'b1;
         wait_req(1'b0);
         check("st_data_hold", 32'(tx_data), 32'(w));
         tx_ack = 1'b0;
         wait_idle();
         check("st_cnt", 32'(xfer_count), 32'(1 + w));
      end
      repeat (3) @(negedge clk);
      check("st_no_extra", 32'(tx_req), 32'd0);
      check("st_cnt_final", 32'(xfer_count), 32'd5);

      // reset while in REQ
      @(negedge clk);
      in_data  = 8'h77;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("mr_req_up", 32'(tx_req), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("mr_req", 32'(tx_req), 32'd0);
      check("mr_busy", 32'(busy), 32'd0);
      check("mr_cnt", 32'(xfer_count), 32'd0);
      check("mr_data", 32'(tx_data), 32'd0);

      // stale ack high across reset release
      tx_ack = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("stale_rdy", 32'(in_ready), 32'd0);
      in_data  = 8'h5A;
      in_valid = 1'b1;
      saw_req  = 1'b0;
      saw_rdy  = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (tx_req)   saw_req = 1'b1;
         if (in_ready) saw_rdy = 1'b1;
      end
      check("stale_no_req", 32'(saw_req), 32'd0);
      check("stale_no_rdy", 32'(saw_rdy), 32'd0);
      tx_ack = 1'b0;
      @(negedge clk);
      check("stale_rdy_e1", 32'(in_ready), 32'd0);
      @(negedge clk);
      check("stale_rdy_e2", 32'(in_ready), 32'd1);
      check("stale_req_e2", 32'(tx_req), 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      check("stale_req_e3", 32'(tx_req), 32'd1);
      check("stale_data", 32'(tx_data), 32'h5A);

      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("cleanup_req", 32'(tx_req), 32'd0);

`ifdef CDC_TX_TIMEOUT_EN
      @(negedge clk);
      in_data  = 8'h3C;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (tx_req && n < 40) begin
         n++;
         @(negedge clk);
      end
      check("to_req_cycles", 32'(n), 32'd8);
      check("to_err", 32'(timeout_err), 32'd1);
      check("to_cnt", 32'(xfer_count), 32'd0);
      @(negedge clk);
      check("to_idle", 32'(busy), 32'd0);
      xfer_word(8'hC3);
      check("to_cnt_after", 32'(xfer_count), 32'd1);
      check("to_err_sticky", 32'(timeout_err), 32'd1);
`else
      n = 0;
      xfer_word(8'hC3);
      check("nt_cnt_after", 32'(xfer_count), 32'(1 + n));
      check("nt_err", 32'(timeout_err), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
